// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit 7-seg scan controller with symbol buffer, scroll and optional blink.
// Optional blink gating is built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl #(
    parameter int SCAN_DIV      = 50000,
    parameter int SCROLL_FRAMES = 125,
    parameter int BLINK_FRAMES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [2:0] wr_data,
    input  logic       scroll_en,
    input  logic       blink,
    output logic [2:0] seg_number,
    output logic [7:0] digit_sel,
    output logic       frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FC_LAST = FW'(SCROLL_FRAMES - 1);
    logic [PW-1:0] ps_q, ps_d;
    logic [FW-1:0] fc_q, fc_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    off_q, off_d;
    logic [2:0]    sym_q [8];
    logic [2:0]    seg_q, seg_d;
    logic [7:0]    sel_q, sel_d;
    logic [7:0]    dsel_q, dsel_d;
    logic          ft_q, ft_d;
    logic          scan_tick, wrap, dark;
`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BLINK_FRAMES - 1);
    logic [BW-1:0] bc_q, bc_d;
    logic          ph_q, ph_d;
    always_comb begin
        bc_d = wrap ? ((bc_q == BC_LAST) ? '0 : bc_q + BW'(1)) : bc_q;
        ph_d = ph_q ^ (wrap && bc_q == BC_LAST);
        dark = blink && ph_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bc_q <= '0;
            ph_q <= 1'b0;
        end else begin
            bc_q <= bc_d;
            ph_q <= ph_d;
        end
    end
`else
    logic blink_unused;
    assign blink_unused = blink;
    assign dark = 1'b0;
`endif
    always_comb begin
        scan_tick = ps_q == PS_LAST;
        wrap      = scan_tick && idx_q == 3'd7;
        ps_d      = scan_tick ? '0 : ps_q + PW'(1);
        idx_d     = idx_q + {2'b0, scan_tick};
        fc_d      = (wrap && scroll_en) ? ((fc_q == FC_LAST) ? '0 : fc_q + FW'(1)) : fc_q;
        off_d     = off_q + {2'b0, wrap && scroll_en && fc_q == FC_LAST};
        // the buffer read uses the pre-write value, so a same-cycle write shows up one cycle later
        seg_d     = sym_q[idx_q + off_q];
        sel_d     = ~(8'd1 << idx_q);
        dsel_d    = dark ? 8'hFF : sel_q;
        ft_d      = wrap;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q   <= '0;
            fc_q   <= '0;
            idx_q  <= '0;
            off_q  <= '0;
            seg_q  <= '0;
            sel_q  <= 8'hFF;
            dsel_q <= 8'hFF;
            ft_q   <= 1'b0;
            for (int i = 0; i < 8; i++) sym_q[i] <= '0;
        end else begin
            ps_q   <= ps_d;
            fc_q   <= fc_d;
            idx_q  <= idx_d;
            off_q  <= off_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            dsel_q <= dsel_d;
            ft_q   <= ft_d;
            if (wr_en) sym_q[wr_addr] <= wr_data;
        end
    end
    assign seg_number = seg_q;
    assign digit_sel  = dsel_q;
    assign frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with SCAN_DIV=4, SCROLL_FRAMES=2, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;
    localparam int SD = 4;
    localparam int SF = 2;
    localparam int BF = 2;
    typedef struct packed {
        logic [2:0] seg;
        logic [7:0] dsel;
        logic       ft;
    } exp_t;
    logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, scroll_en = 1'b0, blink = 1'b0;
    logic [2:0] wr_addr = '0, wr_data = '0;
    logic [2:0] seg_number;
    logic [7:0] digit_sel;
    logic       frame_tick;
    int         n_cmp = 0, n_err = 0, t = 0, m_fc = 0, ft_cnt = 0;
    logic [2:0] m_off = '0, prev_seg = '0;
    logic [7:0] m_selq = 8'hFF;
    logic [2:0] m_buf [8];
    logic [2:0] g [8];
    exp_t       sb_q [$];
    seg_scan_ctrl #(.SCAN_DIV(SD), .SCROLL_FRAMES(SF), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_en(scroll_en), .blink(blink), .seg_number(seg_number),
        .digit_sel(digit_sel), .frame_tick(frame_tick)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // expected outputs derive from the cycle count since reset plus the scroll/buffer history
    task automatic step();
        exp_t e;
        int idx;
        logic [2:0] ai;
        e = '0;
        if (rst) begin
            t = 0; m_fc = 0; m_off = '0; m_selq = 8'hFF;
            for (int i = 0; i < 8; i++) m_buf[i] = '0;
            e.dsel = 8'hFF;
        end else begin
            idx = (t / SD) % 8;
            ai = 3'(idx + int'(m_off));
            e.seg = m_buf[ai];
            e.dsel = m_selq;
`ifdef SEG_SCAN_BLINK_EN
            if (blink && ((t / (8 * SD)) / BF) % 2 == 1) e.dsel = 8'hFF;
`endif
            e.ft = (t % SD == SD - 1) && idx == 7;
            m_selq = ~(8'd1 << idx);
            if (wr_en) m_buf[wr_addr] = wr_data;
            if (e.ft && scroll_en) begin
                if (m_fc == SF - 1) begin
                    m_fc = 0;
                    m_off = m_off + 3'd1;
                end else m_fc++;
            end
            t++;
        end
        sb_q.push_back(e);
        prev_seg = seg_number;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("seg_number", int'(seg_number), int'(e.seg));
        chk("digit_sel", int'(digit_sel), int'(e.dsel));
        chk("frame_tick", int'(frame_tick), int'(e.ft));
        if (frame_tick) ft_cnt++;
    endtask
    task automatic run_align(input int n, input int off);
        logic [2:0] ai;
        for (int k = 0; k < n; k++) begin
            step();
            if (k >= 2 && digit_sel != 8'hFF)
                for (int j = 0; j < 8; j++)
                    if (!digit_sel[j]) begin
                        ai = 3'(j + off);
                        chk("align", int'(prev_seg), int'(g[ai]));
                    end
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int base, n, dark;
        logic [7:0] want;
        logic [2:0] acc;
        g = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 8; i++) m_buf[i] = '0;
        rst = 1'b1;
        step();
        step();
        chk("rst_dsel", int'(digit_sel), 'hFF);
        chk("rst_seg", int'(seg_number), 0);
        rst = 1'b0;
        base = ft_cnt;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (s >= 2 && s <= 30 && (s - 2) % 4 == 0) begin
                want = ~(8'd1 << ((s - 2) / 4));
                chk("scan_seq", int'(digit_sel), int'(want));
            end
        end
        chk("ft_per_32", ft_cnt - base, 1);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = g[i];
            step();
        end
        wr_en = 1'b0;
        run_align(40, 0);
        scroll_en = 1'b1;
        base = ft_cnt;
        n = 0;
        while (m_off != 3'd1 && n < 300) begin step(); n++; end
        chk("reach_off1", int'(m_off == 3'd1), 1);
        chk("scroll_2f", ft_cnt - base, 2);
        run_align(40, 1);
        n = 0;
        while (m_off != 3'd0 && n < 1000) begin step(); n++; end
        scroll_en = 1'b0;
        chk("scroll_16f", ft_cnt - base, 16);
        run_align(80, 0);
        n = 0;
        while (!(((t / SD) % 8) == 2 && t % SD == 0) && n < 100) begin step(); n++; end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 3'd7;
        step();
        chk("wr_old", int'(seg_number), 5);
        wr_en = 1'b0;
        step();
        chk("wr_new", int'(seg_number), 7);
        scroll_en = 1'b1;
        n = 0;
        while (!(m_off == 3'd3 && ((t / SD) % 8) == 5) && n < 3000) begin step(); n++; end
        chk("reach_off3", int'(m_off == 3'd3), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_dsel", int'(digit_sel), 'hFF);
        chk("mid_rst_seg", int'(seg_number), 0);
        rst = 1'b0; scroll_en = 1'b0;
        step();
        step();
        chk("restart_fe", int'(digit_sel), 'hFE);
        acc = '0;
        for (int k = 0; k < 40; k++) begin step(); acc = acc | seg_number; end
        chk("buf_cleared", int'(acc), 0);
        blink = 1'b1;
        dark = 0;
        for (int k = 0; k < 200; k++) begin step(); if (digit_sel == 8'hFF) dark++; end
`ifdef SEG_SCAN_BLINK_EN
        chk("blink_dark", int'(dark > 0), 1);
`else
        chk("no_dark", dark, 0);
`endif
        blink = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scan controller for an 8-digit common-anode 7-segment display.
- Directly upstream of the seven_seg decoder: it drives the decoder's 3-bit seg_number and produces the active-low digit select, delayed so it aligns with the decoder's one-cycle registered output.
- Holds an 8-entry symbol buffer written by the host, and can scroll the message left by one digit at a programmable frame rate.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range >= 2
- SCROLL_FRAMES, 125, full 8-digit frames per scroll step (about 1 s at the defaults); legal range >= 1
- BLINK_FRAMES, 64, frames per blink half-period (used only with the optional feature)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  buffer write strobe, one cycle per write
- wr_addr  in  3  buffer entry to write (0 = leftmost digit)
- wr_data  in  3  symbol code for that entry (1/3/5/7 glyphs, others blank in the decoder)
- scroll_en  in  1  1 = advance the scroll offset every SCROLL_FRAMES frames
- blink  in  1  blink request (used only with the optional feature)
- seg_number  out  3  symbol code to seven_seg, registered
- digit_sel  out  8  active-low one-hot digit enable, registered
- frame_tick  out  1  one-cycle pulse when the digit index wraps 7->0

Behaviour:
- Reset (rst=1 at an edge): prescaler=0, dig_idx=0, frame_cnt=0, offset=0, all buffer entries=0, seg_number=0, digit_sel=8'hFF, internal sel stage=8'hFF, frame_tick=0.
  - Reset mid-scan or mid-scroll aborts immediately; no partial state is retained.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - scan_tick is asserted internally when prescaler==SCAN_DIV-1; the prescaler then wraps to 0.
- Digit index:
  - On scan_tick, dig_idx <= dig_idx+1, wrapping modulo 8.
  - frame_tick=1 in the cycle after dig_idx goes 7->0.
- Scroll:
  - On a 7->0 wrap with scroll_en=1: if frame_cnt==SCROLL_FRAMES-1, then offset <= offset+1 (mod 8) and frame_cnt <= 0; otherwise frame_cnt <= frame_cnt+1.
  - With scroll_en=0, frame_cnt and offset hold.
  - Deasserting scroll_en freezes the display at the current offset.
- Output path, every cycle:
  - seg_number <= buf[(dig_idx+offset) mod 8], i.e. 1 cycle after dig_idx changes.
  - sel_q <= ~(8'b1 << dig_idx).
  - digit_sel <= sel_q.
  - The 2-cycle digit_sel latency equals seg_number's 1 cycle plus the decoder's 1 cycle, so the decoded glyph and its digit enable change on the same edge.
- Buffer writes:
  - On wr_en, buf[wr_addr] <= wr_data.
  - A read of the same entry in the same cycle returns the old value; the new value appears on seg_number no earlier than the following cycle.
  - Writes are accepted in every cycle; there is no back-pressure.
- Simultaneous events: scan_tick, scroll step and a write in one cycle are all applied. The scroll step uses the pre-update offset; the write is independent.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- Defined:
  - A blink phase bit toggles every BLINK_FRAMES frames; its frame counter is reset to 0.
  - While blink=1 and phase=1, digit_sel is forced to 8'hFF (all dark); seg_number is unaffected.
  - Deasserting blink restores normal scanning on the next output register update.
- Undefined: the blink port is present but ignored, no blink counter is built, and digit_sel is never forced.

Test Plan (SCAN_DIV=4, SCROLL_FRAMES=2, BLINK_FRAMES=2):
- Reset, then run 40 cycles with the buffer all 0:
  - digit_sel steps FE,FD,FB,...,7F, each held 4 cycles; seg_number stays 0.
  - frame_tick pulses once per 32 cycles.
- Write buf[0..3] = 1,3,5,7 and hold scroll_en=0: seg_number = 1 when digit_sel==FE two cycles later, 3 with FD, 5 with FB, 7 with F7, and 0 for the other digits.
- Same buffer, scroll_en=1 for 2 frames:
  - offset becomes 1.
  - Digit 0 now shows 3 and digit 3 shows 0.
  - After 16 frames the offset is back to 0.
- Write buf[2]=7 in the same cycle dig_idx becomes 2: the first seg_number shows the old value (5), and the next cycle shows 7.
- Assert rst while offset=3 and dig_idx=5: the next cycle has digit_sel=FF, seg_number=0, all entries 0 and offset 0; scanning restarts at FE.
- With SEG_SCAN_BLINK_EN and blink=1: digit_sel is FF for alternating 2-frame windows. Without the macro, the same stimulus shows no forced dark.
